rtc_bus_arbiter: RTL and testbench
==================================

Name: rtc_bus_arbiter

Overview:
- Shares the RTC parallel address bus between three requesters: write sweep (wr), chrono/timer sweep (cr) and read sweep (rd).
- Grants one requester at a time and walks that requester's fixed register-address list, holding each address for HOLD_CYCLES clocks.
- Signals sweep completion or abort.
- Sits between the top-level mode FSM and the RTC bus driver. Replaces the per-requester address machines.

Parameters:
- HOLD_CYCLES, 74, clocks each address is held on the bus (must be >=2).
- IDLE_ADDR, 8'h00, address value driven when no sweep is active.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- inicio  in  1  init in progress; blocks new grants, sweeps in progress continue
- req_wr  in  1  write-sweep request (level)
- req_cr  in  1  chrono-sweep request (level)
- req_rd  in  1  read-sweep request (level)
- gnt_wr  out  1  write grant
- gnt_cr  out  1  chrono grant
- gnt_rd  out  1  read grant
- address  out  8  RTC register address
- addr_valid  out  1  address is a live sweep address
- addr_idx  out  4  index of current slot within the active list
- slot_last  out  1  final clock of the current address slot
- bus_we  out  1  high for the whole write SWEEP
- done  out  1  one-clock pulse: sweep completed
- abort  out  1  one-clock pulse: sweep cut short

Behaviour:
- Reset values: all gnt_*, addr_valid, bus_we, done, abort and slot_last are 0; address = IDLE_ADDR; addr_idx = 0; state = IDLE. Reset mid-sweep returns to IDLE on the next edge with no done/abort pulse.
- Address lists:
  - WR: 8 entries, 0x21..0x28.
  - CR: 3 entries, 0x41..0x43.
  - RD: 11 entries, 0x21..0x28, then 0x41..0x43.
- States:
  - IDLE: if !inicio, pick the highest-priority active request, priority wr > cr > rd. Latch the owner and go to GRANT.
  - GRANT: exactly 1 clock. The owner's gnt is asserted. Slot counter and addr_idx are cleared. Go to SWEEP.
  - SWEEP:
    - address = list[owner][addr_idx]; addr_valid = 1.
    - Slot counter runs 0..HOLD_CYCLES-1; slot_last = 1 when the count is HOLD_CYCLES-1.
    - On slot_last: if addr_idx == len-1, go to DONE; otherwise addr_idx increments and the counter restarts at 0.
  - DONE: 1 clock. done = 1, all grants drop, addr_valid = 0, address = IDLE_ADDR. Return to IDLE.
  - ABORT: 1 clock. abort = 1, outputs as in DONE. Return to IDLE.
- Timing: request seen in IDLE at clock t, then gnt at t+1, first valid address at t+2, done at t+2+len*HOLD_CYCLES.
- Owner drops its request during GRANT/SWEEP: go to ABORT on the next edge.
- No preemption: a higher-priority request waits until DONE/ABORT finishes. IDLE always lasts at least 1 clock between grants.
- Simultaneous requests: priority order applies. A request still held after its done is re-granted after the IDLE clock, unless a higher-priority request is pending.
- inicio rising mid-sweep: the sweep completes normally. No new grant is issued while inicio = 1.
- Grants are always one-hot or zero. Address is never high-Z.

Optional Feature:
- Macro: RTC_ARB_PREEMPT_EN.
- Defined: req_wr asserted during a cr or rd SWEEP ends the sweep at the next slot_last. It goes to ABORT (abort pulse), then IDLE, and then wr is granted.
- Undefined: no preemption, as in Behaviour.

Decomposition:
- Shared package rtc_pkg holds:
  - state encoding (IDLE, GRANT, SWEEP, DONE, ABORT);
  - owner encoding (OWN_WR, OWN_CR, OWN_RD);
  - list lengths (8, 3, 11);
  - RTC register address constants 0x21..0x28 and 0x41..0x43.
- One sub-module: rtc_addr_rom, a combinational mapping of (owner, idx) to address.

Test Plan:
- reset, then req_rd=1 held:
  - gnt_rd at t+1 and address 0x21 at t+2;
  - 0x22 at t+2+74;
  - last address 0x43 (idx 10);
  - done at t+2+814, then gnt_rd re-asserts 2 clocks later.
- req_wr, req_cr, req_rd all asserted in the same cycle: gnt_wr only; after the 8-address sweep, done, then gnt_cr (not gnt_rd).
- req_cr dropped during slot idx 1 (address 0x42): abort pulse next clock, addr_valid=0, address=0x00, no done pulse.
- inicio=1 with req_rd=1: no grant while inicio is high. Deassert inicio: gnt_rd on the next clock.
- reset asserted mid-write sweep (address 0x25): next clock all outputs at reset values and bus_we=0, with no done/abort pulse.
- With RTC_ARB_PREEMPT_EN: req_wr rises mid-slot idx 3 of a read sweep. Address 0x24 is held until slot_last, then abort pulse, then gnt_wr 2 clocks later. Without the macro: the read sweep completes before gnt_wr.

Source files
------------

// File: rtl/rtc_bus_arbiter_pkg.sv
// rtc_pkg -- shared definitions for the RTC bus arbiter.
//
// Contents:
//   state_t   : arbiter FSM states (IDLE, GRANT, SWEEP, DONE, ABORT)
//   owner_t   : requester identity (write, chrono, read sweep)
//   LEN_*     : number of register addresses walked by each requester
//   WR_ADDRS  : time/date register block 0x21..0x28 (index 0 = 0x21)
//   CR_ADDRS  : chrono/timer register block 0x41..0x43 (index 0 = 0x41)
//   list_len(): length of the address list owned by a requester
package rtc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_SWEEP = 3'd2,
        ST_DONE  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OWN_WR = 2'd0,
        OWN_CR = 2'd1,
        OWN_RD = 2'd2
    } owner_t;

    localparam logic [3:0] LEN_WR = 4'd8;
    localparam logic [3:0] LEN_CR = 4'd3;
    localparam logic [3:0] LEN_RD = 4'd11;

    // Packed tables: element [0] is the first address of the list.
    localparam logic [7:0][7:0] WR_ADDRS = {
        8'h28, 8'h27, 8'h26, 8'h25, 8'h24, 8'h23, 8'h22, 8'h21
    };
    localparam logic [2:0][7:0] CR_ADDRS = {
        8'h43, 8'h42, 8'h41
    };

    function automatic logic [3:0] list_len(input owner_t owner);
        case (owner)
            OWN_WR:  list_len = LEN_WR;
            OWN_CR:  list_len = LEN_CR;
            OWN_RD:  list_len = LEN_RD;
            default: list_len = 4'd1;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_arbiter_addr_rom.sv
// rtc_addr_rom -- combinational (owner, slot index) -> RTC register address.
//
// Ports:
//   owner : requester whose list is being walked
//   idx   : slot index within that list
//   addr  : register address; 8'h00 for an index outside the list
//
// The read list is the write block followed by the chrono block, so it is
// built from the two shared tables instead of a third copy.
module rtc_addr_rom
    import rtc_pkg::*;
(
    input  owner_t     owner,
    input  logic [3:0] idx,
    output logic [7:0] addr
);

    logic [3:0] cr_off;

    always_comb begin
        addr   = 8'h00;
        cr_off = idx - 4'd8;
        case (owner)
            OWN_WR: begin
                if (idx < LEN_WR) begin
                    addr = WR_ADDRS[idx[2:0]];
                end
            end
            OWN_CR: begin
                if (idx < LEN_CR) begin
                    addr = CR_ADDRS[idx[1:0]];
                end
            end
            OWN_RD: begin
                if (idx < LEN_WR) begin
                    addr = WR_ADDRS[idx[2:0]];
                end else if (idx < LEN_RD) begin
                    addr = CR_ADDRS[cr_off[1:0]];
                end
            end
            default: addr = 8'h00;
        endcase
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter -- shares the RTC parallel address bus between the write
// sweep (wr), chrono sweep (cr) and read sweep (rd). One requester is granted
// at a time; its fixed address list is walked with every address held for
// HOLD_CYCLES clocks, then done (or abort) is pulsed for one clock.
//
// Parameters:
//   HOLD_CYCLES : clocks each address stays on the bus (>= 2)
//   IDLE_ADDR   : address driven while no sweep is active
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   inicio                : init in progress, blocks new grants only
//   req_wr/req_cr/req_rd  : level requests, priority wr > cr > rd
//   gnt_wr/gnt_cr/gnt_rd  : one-hot grants, high through GRANT and SWEEP
//   address, addr_valid   : current sweep address and its qualifier
//   addr_idx, slot_last   : slot index in the list, final clock of the slot
//   bus_we                : high throughout a write sweep
//   done, abort           : one-clock completion / cut-short pulses
//
// Build option: define RTC_ARB_PREEMPT_EN to let req_wr cut a cr/rd sweep
// short at its next slot boundary (abort, then the write sweep is granted).
module rtc_bus_arbiter
    import rtc_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 74,
    parameter logic [7:0]  IDLE_ADDR   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inicio,
    input  logic       req_wr,
    input  logic       req_cr,
    input  logic       req_rd,
    output logic       gnt_wr,
    output logic       gnt_cr,
    output logic       gnt_rd,
    output logic [7:0] address,
    output logic       addr_valid,
    output logic [3:0] addr_idx,
    output logic       slot_last,
    output logic       bus_we,
    output logic       done,
    output logic       abort
);

    localparam int unsigned SLOT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [3:0]        idx_q, idx_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              owner_req;
    logic              slot_end;
    logic              list_end;
    logic              preempt_now;
    logic [7:0]        rom_addr;

`ifdef RTC_ARB_PREEMPT_EN
    logic preempt_q, preempt_d;

    // A write request seen at any point of a cr/rd sweep is remembered so a
    // short pulse on req_wr still ends the sweep at the next slot boundary.
    assign preempt_now = (owner_q != OWN_WR) && (preempt_q || req_wr);

    always_comb begin
        preempt_d = (state_q == ST_SWEEP) && (state_d == ST_SWEEP) && preempt_now;
    end
`else
    assign preempt_now = 1'b0;
`endif

    rtc_addr_rom u_addr_rom (
        .owner (owner_q),
        .idx   (idx_q),
        .addr  (rom_addr)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        idx_d     = idx_q;
        slot_d    = slot_q;
        owner_req = 1'b0;
        slot_end  = (slot_q == SLOT_LAST);
        list_end  = (idx_q == (list_len(owner_q) - 4'd1));

        case (owner_q)
            OWN_WR:  owner_req = req_wr;
            OWN_CR:  owner_req = req_cr;
            OWN_RD:  owner_req = req_rd;
            default: owner_req = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (!inicio && (req_wr || req_cr || req_rd)) begin
                    state_d = ST_GRANT;
                    if (req_wr) begin
                        owner_d = OWN_WR;
                    end else if (req_cr) begin
                        owner_d = OWN_CR;
                    end else begin
                        owner_d = OWN_RD;
                    end
                end
            end
            ST_GRANT: begin
                state_d = owner_req ? ST_SWEEP : ST_ABORT;
            end
            ST_SWEEP: begin
                // A withdrawn request wins over everything, including the
                // final slot boundary of the list.
                if (!owner_req) begin
                    state_d = ST_ABORT;
                end else if (slot_end) begin
                    if (list_end) begin
                        state_d = ST_DONE;
                    end else if (preempt_now) begin
                        state_d = ST_ABORT;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        slot_d = '0;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Counters only carry meaning inside a sweep; everywhere else they
        // sit at zero so the next GRANT starts from a clean slot 0 / index 0.
        if (state_d != ST_SWEEP) begin
            idx_d  = 4'd0;
            slot_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_WR;
            idx_q   <= 4'd0;
            slot_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            slot_q  <= slot_d;
        end
    end

`ifdef RTC_ARB_PREEMPT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            preempt_q <= 1'b0;
        end else begin
            preempt_q <= preempt_d;
        end
    end
`endif

    // Outputs decode the registered state only, so they are stable for the
    // whole clock and cannot glitch on request inputs.
    logic granted;
    logic sweeping;

    assign granted    = (state_q == ST_GRANT) || (state_q == ST_SWEEP);
    assign sweeping   = (state_q == ST_SWEEP);

    assign gnt_wr     = granted && (owner_q == OWN_WR);
    assign gnt_cr     = granted && (owner_q == OWN_CR);
    assign gnt_rd     = granted && (owner_q == OWN_RD);
    assign address    = sweeping ? rom_addr : IDLE_ADDR;
    assign addr_valid = sweeping;
    assign addr_idx   = idx_q;
    assign slot_last  = sweeping && slot_end;
    assign bus_we     = sweeping && (owner_q == OWN_WR);
    assign done       = (state_q == ST_DONE);
    assign abort      = (state_q == ST_ABORT);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Testbench for rtc_bus_arbiter: directed scenarios followed by random
// request/inicio/reset traffic. A sweep-level reference model (owner plus
// cycles elapsed since the grant) predicts the full output vector for every
// clock; predictions are queued and a separate monitor compares them on the
// falling edge.
module tb_rtc_bus_arbiter;

    localparam int H = 74;

    logic       clk = 1'b0;
    logic       reset, inicio, req_wr, req_cr, req_rd;
    logic       gnt_wr, gnt_cr, gnt_rd;
    logic [7:0] address;
    logic       addr_valid;
    logic [3:0] addr_idx;
    logic       slot_last, bus_we, done, abort;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    rtc_bus_arbiter #(.HOLD_CYCLES(H), .IDLE_ADDR(8'h00)) dut (
        .clk        (clk),
        .reset      (reset),
        .inicio     (inicio),
        .req_wr     (req_wr),
        .req_cr     (req_cr),
        .req_rd     (req_rd),
        .gnt_wr     (gnt_wr),
        .gnt_cr     (gnt_cr),
        .gnt_rd     (gnt_rd),
        .address    (address),
        .addr_valid (addr_valid),
        .addr_idx   (addr_idx),
        .slot_last  (slot_last),
        .bus_we     (bus_we),
        .done       (done),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_owner: -1 none, 0 wr, 1 cr, 2 rd.  m_age: 0 on the grant clock,
    // k+1 on the k-th clock of the sweep.  m_pulse: 1 done, 2 abort.
    int m_owner = -1;
    int m_age   = 0;
    int m_pulse = 0;
    bit m_pre   = 0;

    logic [19:0] exp_q[$];
    int          exp_cyc_q[$];

    function automatic int len_of(int o);
        return (o == 0) ? 8 : (o == 1) ? 3 : 11;
    endfunction

    function automatic int addr_of(int o, int k);
        if (o == 0) return 8'h21 + k;
        if (o == 1) return 8'h41 + k;
        return (k < 8) ? (8'h21 + k) : (8'h41 + k - 8);
    endfunction

    task automatic model_step();
        bit          oreq;
        int          k;
        logic [2:0]  g;
        logic [7:0]  a;
        logic        v, sl, we, dn, ab;
        logic [3:0]  ix;
        if (reset) begin
            m_owner = -1; m_pulse = 0; m_pre = 0; m_age = 0;
        end else if (m_pulse != 0) begin
            m_pulse = 0;
        end else if (m_owner < 0) begin
            if (!inicio && (req_wr || req_cr || req_rd)) begin
                m_owner = req_wr ? 0 : (req_cr ? 1 : 2);
                m_age = 0; m_pre = 0;
            end
        end else begin
            oreq = (m_owner == 0) ? req_wr : (m_owner == 1) ? req_cr : req_rd;
            if (!oreq) begin
                m_owner = -1; m_pulse = 2;
            end else if (m_age == 0) begin
                m_age = 1;
            end else begin
                k = m_age - 1;
`ifdef RTC_ARB_PREEMPT_EN
                if (m_owner != 0 && req_wr) m_pre = 1;
`endif
                if (k % H == H - 1) begin
                    if (k / H == len_of(m_owner) - 1) begin
                        m_owner = -1; m_pulse = 1;
                    end else if (m_pre) begin
                        m_owner = -1; m_pulse = 2;
                    end else begin
                        m_age++;
                    end
                end else begin
                    m_age++;
                end
            end
        end
        g  = (m_owner == 0) ? 3'b100 : (m_owner == 1) ? 3'b010 : (m_owner == 2) ? 3'b001 : 3'b000;
        v  = (m_owner >= 0) && (m_age >= 1);
        a  = v ? 8'(addr_of(m_owner, (m_age - 1) / H)) : 8'h00;
        ix = v ? 4'((m_age - 1) / H) : 4'd0;
        sl = v && ((m_age - 1) % H == H - 1);
        we = v && (m_owner == 0);
        dn = (m_pulse == 1);
        ab = (m_pulse == 2);
        exp_q.push_back({g, a, v, ix, sl, we, dn, ab});
        exp_cyc_q.push_back(cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_step();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [19:0] e, a;
        int          c;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                c = exp_cyc_q.pop_front();
                a = {gnt_wr, gnt_cr, gnt_rd, address, addr_valid, addr_idx,
                     slot_last, bus_we, done, abort};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    if (n_bad <= 40)
                        $display("FAIL outputs cyc=%0d: got gnt=%b addr=%h v=%b idx=%0d last=%b we=%b done=%b abort=%b; want gnt=%b addr=%h v=%b idx=%0d last=%b we=%b done=%b abort=%b",
                                 c, a[19:17], a[16:9], a[8], a[7:4], a[3], a[2], a[1], a[0],
                                 e[19:17], e[16:9], e[8], e[7:4], e[3], e[2], e[1], e[0]);
                end
                if (e[1] || e[0])
                    $display("cyc %0d: sweep end, done=%b abort=%b (dut done=%b abort=%b)",
                             c, e[1], e[0], a[1], a[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int n;
        reset = 1'b1; inicio = 1'b0; req_wr = 1'b0; req_cr = 1'b0; req_rd = 1'b0;
        ticks(3);
        reset = 1'b0;
        ticks(2);

        // Read sweep held: full 11-address sweep, re-grant, then dropped mid-sweep.
        req_rd = 1'b1;
        ticks(1000);
        req_rd = 1'b0;
        ticks(5);

        // All three together: wr first; release wr at its done so cr follows.
        req_wr = 1'b1; req_cr = 1'b1; req_rd = 1'b1;
        n = 0;
        tick();
        while (!done && n < 1000) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!done) begin
            n_bad++;
            $display("FAIL wr_done_wait: got no done within %0d clocks, required a done pulse", n);
        end
        req_wr = 1'b0;
        // cr granted two clocks later; drop it while slot idx 1 (0x42) is live.
        ticks(2 + H + 30);
        req_cr = 1'b0;
        ticks(40);
        req_rd = 1'b0;
        ticks(5);

        // inicio blocks new grants.
        inicio = 1'b1; req_rd = 1'b1;
        ticks(40);
        inicio = 1'b0;
        ticks(10);
        req_rd = 1'b0;
        ticks(5);

        // Reset in the middle of a write sweep (address 0x25).
        req_wr = 1'b1;
        ticks(2 + 4 * H + 20);
        reset = 1'b1; req_wr = 1'b0;
        tick();
        reset = 1'b0;
        ticks(5);

        // req_wr arrives during slot idx 3 of a read sweep.
        req_rd = 1'b1;
        ticks(2 + 3 * H + 20);
        req_wr = 1'b1;
        ticks(1800);
        req_wr = 1'b0; req_rd = 1'b0;
        ticks(5);

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) req_wr = ~req_wr;
            if ($urandom_range(0, 199) == 0) req_cr = ~req_cr;
            if ($urandom_range(0, 149) == 0) req_rd = ~req_rd;
            if ($urandom_range(0, 399) == 0) inicio = ~inicio;
            reset = ($urandom_range(0, 4999) == 0);
            tick();
        end
        reset = 1'b0; req_wr = 1'b0; req_cr = 1'b0; req_rd = 1'b0; inicio = 1'b0;
        ticks(5);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d unchecked predictions, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
